// File: rtl/fft_lane_serializer_pkg.sv
// Shared definitions for the butterfly lane serializer: state encoding,
// lane-index width and default pointer stride.
package fft_lane_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Lanes land in opposite halves of the next stage's address space by default.
  function automatic int default_stride(input int size);
    return 1 << (size - 1);
  endfunction

endpackage

// File: rtl/fft_lane_serializer_if.sv
// Producer/consumer bundle for the lane serializer.
// Handshake: a side transfers on a rising edge only when its valid and ready are
// both high; the sender holds data stable while valid is high and ready is low.
interface fft_lane_serializer_if
  import fft_lane_serializer_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int SIZE      = 8,
  parameter int LANES     = 2
);
  localparam int LW = lane_w(LANES);

  logic [SIZE-1:0]            rd_ptr;
  logic [LANES*bit_width-1:0] Re_i;
  logic [LANES*bit_width-1:0] Im_i;
  logic                       in_valid;
  logic                       in_ready;
  logic                       out_ready;
  logic [bit_width-1:0]       Re_o;
  logic [bit_width-1:0]       Im_o;
  logic [SIZE-1:0]            wr_ptr;
  logic [LW-1:0]              lane_idx;
  logic                       last;
  logic                       out_valid;
  state_t                     dbg_state;

  modport slave (
    input  rd_ptr, Re_i, Im_i, in_valid, out_ready,
    output in_ready, Re_o, Im_o, wr_ptr, lane_idx, last, out_valid, dbg_state
  );

  modport master (
    output rd_ptr, Re_i, Im_i, in_valid, out_ready,
    input  in_ready, Re_o, Im_o, wr_ptr, lane_idx, last, out_valid, dbg_state
  );

endinterface

// File: rtl/fft_ptr_delay.sv
// Free-running register chain aligning rd_ptr with butterfly output latency.
// DEPTH of 0 degenerates to a plain wire.
module fft_ptr_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_chain
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_lane_serializer.sv
// Serializes LANES complex butterfly outputs into one stream with a strided
// write pointer for the next stage's memory.
module fft_lane_serializer
  import fft_lane_serializer_pkg::*;
#(
  parameter int bit_width   = 16,
  parameter int SIZE        = 8,
  parameter int LANES       = 2,
  parameter int PTR_DELAY   = 3,
  parameter int LANE_STRIDE = default_stride(SIZE)
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_lane_serializer_if.slave bus
);

  localparam int              LW        = lane_w(LANES);
  localparam logic [SIZE-1:0] STRIDE    = SIZE'(LANE_STRIDE);
  localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);

  state_t               state;
  logic [SIZE-1:0]      ptr_d;
  logic [bit_width-1:0] re_bank [LANES];
  logic [bit_width-1:0] im_bank [LANES];
  logic                 accept;
  logic [LW-1:0]        lane_nxt;

  fft_ptr_delay #(.WIDTH(SIZE), .DEPTH(PTR_DELAY)) u_ptr_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rd_ptr),
    .q     (ptr_d)
  );

  // Accepting on the final lane's departure keeps back-to-back transfers bubble-free.
  assign bus.in_ready = rst_n && ((state == IDLE) ||
                        (state == EMIT && bus.last && bus.out_valid && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign lane_nxt      = bus.lane_idx + 1'b1;
  assign bus.dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.Re_o      <= '0;
      bus.Im_o      <= '0;
      bus.wr_ptr    <= '0;
      bus.lane_idx  <= '0;
      bus.last      <= 1'b0;
      bus.out_valid <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        re_bank[k] <= '0;
        im_bank[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        re_bank[k] <= bus.Re_i[k*bit_width +: bit_width];
        im_bank[k] <= bus.Im_i[k*bit_width +: bit_width];
      end
      state         <= EMIT;
      bus.out_valid <= 1'b1;
      bus.Re_o      <= bus.Re_i[bit_width-1:0];
      bus.Im_o      <= bus.Im_i[bit_width-1:0];
      bus.wr_ptr    <= ptr_d;
      bus.lane_idx  <= '0;
      bus.last      <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        EMIT: begin
          if (bus.out_ready) begin
            if (!bus.last) begin
              // Stepping the pointer by STRIDE equals base + k*STRIDE modulo 2**SIZE.
              bus.Re_o     <= re_bank[lane_nxt];
              bus.Im_o     <= im_bank[lane_nxt];
              bus.wr_ptr   <= bus.wr_ptr + STRIDE;
              bus.lane_idx <= lane_nxt;
              bus.last     <= (lane_nxt == LAST_LANE);
            end else begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_lane_serializer.md
Name: fft_lane_serializer

Overview:
Parametrised successor to the two-input butterfly output multiplexor. It accepts LANES complex samples per transfer from a radix butterfly stage and emits them one per cycle as a single complex stream with a computed write pointer for the next stage's RAM. It adds a valid/ready handshake on both sides, a generalised lane count, a configurable pointer delay, and per-lane pointer striding. It sits between each butterfly stage and its ping-pong memory write port.

Parameters:
bit_width, 16, width of each real/imag component (signed)
SIZE, 8, address/pointer width
LANES, 2, complex samples per input transfer (>=2)
PTR_DELAY, 3, pipeline depth from rd_ptr to the base pointer; 0 = rd_ptr used directly
LANE_STRIDE, 2**(SIZE-1), pointer increment between consecutive lanes (mod 2**SIZE)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_ptr  in  SIZE  read pointer of the current butterfly operands
Re_i  in  LANES*bit_width  real parts, lane k at [k*bit_width +: bit_width]
Im_i  in  LANES*bit_width  imag parts, same packing
in_valid  in  1  input transfer valid
in_ready  out  1  block can accept a transfer this cycle
out_ready  in  1  downstream accepts the current output
Re_o  out  bit_width  serialized real sample (signed)
Im_o  out  bit_width  serialized imag sample (signed)
wr_ptr  out  SIZE  write address for Re_o/Im_o
lane_idx  out  max(1,$clog2(LANES))  lane number of the current output
last  out  1  high on the final lane of a transfer
out_valid  out  1  output valid

Behaviour:
- Reset (async, rst_n low): state IDLE, lane counter 0; Re_o, Im_o, wr_ptr, lane_idx, last, out_valid all 0; delay line cleared to 0; in_ready low while rst_n low.
- Pointer delay: rd_ptr passes through a free-running PTR_DELAY-stage register chain, advancing every cycle regardless of the handshake; the chain output is ptr_d.
- Accept: the handshake fires when in_valid && in_ready on a rising edge. It captures all lanes of Re_i/Im_i into a holding bank and captures base = ptr_d.
- in_ready = (state==IDLE) || (state==EMIT && last && out_valid && out_ready). This is combinational, so back-to-back transfers have no bubble.
- States:
  - IDLE: out_valid=0. On accept, go to EMIT; next cycle presents lane 0.
  - EMIT: outputs are registered.
    - If out_valid && !out_ready: hold every output stable (stall).
    - If out_ready and not last: advance to the next lane.
    - If out_ready and last: if an accept fires the same cycle, present lane 0 of the new transfer next cycle; otherwise go to IDLE with out_valid=0.
- Output for lane k: Re_o/Im_o = held lane k; wr_ptr = (base + k*LANE_STRIDE) mod 2**SIZE, truncated to SIZE bits and wrapping silently; lane_idx = k; last = (k==LANES-1).
- Latency: one cycle from accept to lane 0 at the output. Throughput is one transfer per LANES cycles with out_ready held high.
- in_valid while !in_ready: no capture. The producer must hold its data; the block takes no action on it.
- Reset mid-transfer: remaining lanes are discarded, and outputs return to reset values immediately.
- Sample data is passed unmodified; no arithmetic is applied to Re/Im.

Decomposition:
- Shared fft package holds the lane-index width function (max(1,$clog2(n))), the IDLE/EMIT state encoding, and the default LANE_STRIDE expression.
- One natural sub-module: fft_ptr_delay, a parametrised width/depth register chain with async reset, depth 0 = wire. It replaces the fixed-depth shift register.

Test Plan:
- Single transfer, LANES=2, PTR_DELAY=3, rd_ptr=0x05 held ≥3 cycles, lanes (100,-100),(200,-200), out_ready=1 → two cycles: (100,-100,wr_ptr 0x05,lane 0,last 0) then (200,-200,0x85,lane 1,last 1), then out_valid=0.
- Back-to-back: in_valid held high for 3 transfers → out_valid continuous for 6 cycles; in_ready pulses only on last-lane cycles.
- Stall: out_ready=0 for 4 cycles during lane 0 → outputs frozen and in_ready=0; lane 1 follows the cycle after out_ready rises.
- Wrap: SIZE=8, LANES=4, LANE_STRIDE=64, base 0xF0 → wr_ptr sequence 0xF0,0x30,0x70,0xB0.
- PTR_DELAY=0: rd_ptr changes every cycle → base equals rd_ptr sampled on the accept edge.
- Reset asserted mid-EMIT (lane 1 of 4) → all outputs 0 asynchronously; after release, in_ready=1 and a fresh transfer emits correctly from lane 0.
